// File: rtl/cache_ram_port_arbiter_if.sv
// Bundle of every signal exchanged between the cache-side requesters, the
// main-memory port arbiter and the RAM. The arbiter uses the slave modport;
// the environment around it (caches and RAM) uses the master modport.
interface cache_ram_port_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int RAM_AW = 32,
    parameter int BEATS  = 4
);
    logic                  instr_req_i;
    logic [ADDR_W-1:0]     instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_done_o;
    logic                  data_req_i;
    logic                  data_we_i;
    logic [ADDR_W-1:0]     data_addr_i;
    logic [63:0]           data_wdata_i;
    logic [7:0]            data_wstrb_i;
    logic                  data_gnt_o;
    logic                  data_done_o;
    logic [32*BEATS-1:0]   line_o;
    logic                  busy_o;
    logic                  ram_read_o;
    logic                  ram_write_o;
    logic [RAM_AW-1:0]     ram_addr_o;
    logic [31:0]           ram_data_o;
    logic [3:0]            wr_strb_o;
    logic [31:0]           ram_data_i;
    logic                  ram_ack_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i, data_wstrb_i,
        input  ram_data_i, ram_ack_i,
        output instr_gnt_o, instr_done_o, data_gnt_o, data_done_o,
        output line_o, busy_o,
        output ram_read_o, ram_write_o, ram_addr_o, ram_data_o, wr_strb_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i, data_wstrb_i,
        output ram_data_i, ram_ack_i,
        input  instr_gnt_o, instr_done_o, data_gnt_o, data_done_o,
        input  line_o, busy_o,
        input  ram_read_o, ram_write_o, ram_addr_o, ram_data_o, wr_strb_o
    );
endinterface

// File: rtl/cache_ram_port_arbiter.sv
// Main-memory port arbiter: shares one 32-bit RAM port between L1 instruction
// refills and L1 data traffic. A refill reads BEATS words into line_o; a
// write-through issues up to two 32-bit beats, skipping beats whose strobe
// nibble is zero. All outputs come straight from flops.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin on simultaneous
// requests). Without it data always wins over instruction.
module cache_ram_port_arbiter #(
    parameter int ADDR_W = 19,
    parameter int RAM_AW = 32,
    parameter int BEATS  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cache_ram_port_arbiter_if.slave bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_base;
    logic [31:0]         r_wdata_hi;
    logic [3:0]          r_wstrb_hi;
    logic                r_is_data;
    logic [32*BEATS-1:0] r_line;
    logic                r_instr_gnt;
    logic                r_data_gnt;
    logic                r_instr_done;
    logic                r_data_done;
    logic                r_busy;
    logic                r_ram_read;
    logic                r_ram_write;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [31:0]         r_ram_data;
    logic [3:0]          r_wr_strb;
`ifdef CACHE_ARB_RR_EN
    logic                r_last_data;
`endif

    logic                w_req_any;
    logic                w_pick_data;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [ADDR_W-1:0]   w_line_base;
    logic [ADDR_W-1:0]   w_word_base;

    // RAM byte address of beat idx: zero-extended base plus 4 bytes per beat
    function automatic logic [RAM_AW-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return RAM_AW'(base) + (RAM_AW'(idx) << 2'd2);
    endfunction

    // Pick the requester to serve and derive its aligned base addresses
    always_comb begin
        w_req_any = bus.instr_req_i | bus.data_req_i;
`ifdef CACHE_ARB_RR_EN
        if (bus.instr_req_i && bus.data_req_i) begin
            w_pick_data = ~r_last_data;
        end else begin
            w_pick_data = bus.data_req_i;
        end
`else
        w_pick_data = bus.data_req_i;
`endif
        if (w_pick_data) begin
            w_sel_addr = bus.data_addr_i;
            w_sel_we   = bus.data_we_i;
        end else begin
            w_sel_addr = bus.instr_addr_i;
            w_sel_we   = 1'b0;
        end
        w_line_base = w_sel_addr & {{(ADDR_W-4){1'b1}}, 4'h0};
        w_word_base = w_sel_addr & {{(ADDR_W-3){1'b1}}, 3'h0};
    end

    // Grant, beat sequencing, line assembly and every registered output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_cnt        <= CNT_ZERO;
            r_base       <= {ADDR_W{1'b0}};
            r_wdata_hi   <= 32'h0;
            r_wstrb_hi   <= 4'h0;
            r_is_data    <= 1'b0;
            r_line       <= {(32*BEATS){1'b0}};
            r_instr_gnt  <= 1'b0;
            r_data_gnt   <= 1'b0;
            r_instr_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_ram_read   <= 1'b0;
            r_ram_write  <= 1'b0;
            r_ram_addr   <= {RAM_AW{1'b0}};
            r_ram_data   <= 32'h0;
            r_wr_strb    <= 4'h0;
`ifdef CACHE_ARB_RR_EN
            r_last_data  <= 1'b0;
`endif
        end else begin
            // gnt and done are single-cycle pulses
            r_instr_gnt  <= 1'b0;
            r_data_gnt   <= 1'b0;
            r_instr_done <= 1'b0;
            r_data_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_is_data   <= w_pick_data;
                        r_instr_gnt <= ~w_pick_data;
                        r_data_gnt  <= w_pick_data;
`ifdef CACHE_ARB_RR_EN
                        r_last_data <= w_pick_data;
`endif
                        r_wdata_hi  <= bus.data_wdata_i[63:32];
                        r_wstrb_hi  <= bus.data_wstrb_i[7:4];
                        r_busy      <= 1'b1;
                        if (w_sel_we) begin
                            r_state <= WR;
                            r_base  <= w_word_base;
                            // First beat is the lowest word that has any strobe set
                            if (bus.data_wstrb_i[3:0] != 4'h0) begin
                                r_cnt       <= CNT_ZERO;
                                r_ram_write <= 1'b1;
                                r_ram_addr  <= beat_addr(w_word_base, CNT_ZERO);
                                r_ram_data  <= bus.data_wdata_i[31:0];
                                r_wr_strb   <= bus.data_wstrb_i[3:0];
                            end else if (bus.data_wstrb_i[7:4] != 4'h0) begin
                                r_cnt       <= CNT_ONE;
                                r_ram_write <= 1'b1;
                                r_ram_addr  <= beat_addr(w_word_base, CNT_ONE);
                                r_ram_data  <= bus.data_wdata_i[63:32];
                                r_wr_strb   <= bus.data_wstrb_i[7:4];
                            end else begin
                                r_cnt       <= CNT_ZERO;
                                r_ram_write <= 1'b0;
                                r_wr_strb   <= 4'h0;
                            end
                        end else begin
                            r_state    <= RD;
                            r_base     <= w_line_base;
                            r_cnt      <= CNT_ZERO;
                            r_ram_read <= 1'b1;
                            r_ram_addr <= beat_addr(w_line_base, CNT_ZERO);
                            r_wr_strb  <= 4'h0;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                RD: begin
                    if (bus.ram_ack_i) begin
                        r_line[32*r_cnt +: 32] <= bus.ram_data_i;
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt      <= CNT_ZERO;
                            r_ram_read <= 1'b0;
                            r_state    <= DONE;
                        end else begin
                            r_cnt      <= r_cnt + CNT_ONE;
                            r_ram_addr <= beat_addr(r_base, r_cnt + CNT_ONE);
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                WR: begin
                    if (!r_ram_write) begin
                        // Both strobe nibbles were zero: nothing to send
                        r_state <= DONE;
                    end else if (bus.ram_ack_i) begin
                        if ((r_cnt == CNT_ZERO) && (r_wstrb_hi != 4'h0)) begin
                            r_cnt      <= CNT_ONE;
                            r_ram_addr <= beat_addr(r_base, CNT_ONE);
                            r_ram_data <= r_wdata_hi;
                            r_wr_strb  <= r_wstrb_hi;
                        end else begin
                            r_cnt       <= CNT_ZERO;
                            r_ram_write <= 1'b0;
                            r_wr_strb   <= 4'h0;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_instr_done <= ~r_is_data;
                    r_data_done  <= r_is_data;
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_ram_read  <= 1'b0;
                    r_ram_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_gnt_o  = r_instr_gnt;
    assign bus.instr_done_o = r_instr_done;
    assign bus.data_gnt_o   = r_data_gnt;
    assign bus.data_done_o  = r_data_done;
    assign bus.line_o       = r_line;
    assign bus.busy_o       = r_busy;
    assign bus.ram_read_o   = r_ram_read;
    assign bus.ram_write_o  = r_ram_write;
    assign bus.ram_addr_o   = r_ram_addr;
    assign bus.ram_data_o   = r_ram_data;
    assign bus.wr_strb_o    = r_wr_strb;
endmodule
